uart_mem_loader: RTL and testbench
==================================

// Module: uart_mem_loader
// PURPOSE
//  Boot loader upstream of the CPU top. Consumes a byte stream from the UART receiver and
//  assembles little-endian 32-bit words. Drives the top's external-write port
//  (Ext_MemWrite/Ext_WriteData/Ext_DataAdr) into data memory while holding the CPU in reset.
//  Releases the CPU after a frame passes its checksum.
//  Frame: SYNC, CNT_LO, CNT_HI, 4*N data bytes, CHK. CHK = XOR of all data bytes.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first word written
//  MAX_WORDS  64             data_mem capacity in words; a larger N is rejected
//  SYNC_BYTE  8'hA5          frame start byte
// PORTS
//  clk            in   1   single system clock
//  reset          in   1   asynchronous, active-LOW reset
//  rx_data        in   8   received byte
//  rx_valid       in   1   rx_data valid
//  rx_ready       out  1   byte accepted on a rising edge when rx_valid && rx_ready
//  cpu_reset      out  1   active-high hold to the CPU top's reset input
//  ext_mem_write  out  1   one-cycle write strobe into data memory
//  ext_write_data out  32  assembled word
//  ext_data_adr   out  32  word byte address
//  load_done      out  1   last frame loaded OK; CPU running
//  load_err       out  1   last frame rejected (size or checksum)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cpu_reset=1, rx_ready=1, ext_mem_write=0,
//   ext_write_data=0, ext_data_adr=BASE_ADDR, load_done=0, load_err=0, counters and checksum 0.
//  The CPU stays held after reset until a good frame completes. There is no auto-run.
//  States (all accept one byte per handshake unless noted):
//   IDLE  : discard bytes != SYNC_BYTE. SYNC -> CNT_LO; clear checksum, byte index, word count.
//   CNT_LO: latch N[7:0] -> CNT_HI.
//   CNT_HI: latch N[15:8].
//           N > MAX_WORDS -> ERR.
//           N == 0 -> CHK.
//           Otherwise -> DATA with addr=BASE_ADDR.
//   DATA  : byte i (0..3) -> word[8i+7:8i]; checksum ^= byte. On byte 3 -> WRITE.
//   WRITE : rx_ready=0. ext_mem_write=1 for exactly this cycle, with data and addr stable.
//           Then addr += 4 and words_done += 1.
//           words_done == N -> CHK, else -> DATA.
//           The write occurs the cycle after the 4th byte is accepted (latency 1).
//   CHK   : byte == checksum -> RUN, else -> ERR.
//   RUN   : cpu_reset=0, load_done=1. SYNC byte -> CNT_LO, with cpu_reset=1 and load_done=0
//           from the next cycle (reload). Other bytes are discarded.
//   ERR   : cpu_reset=1, load_err=1. SYNC -> CNT_LO, and load_err clears on that transition.
//  Invariants:
//   - cpu_reset is 1 in every cycle ext_mem_write=1.
//   - ext_mem_write is never high outside WRITE.
//   - addr wraps modulo 2^32 (unreachable while N <= MAX_WORDS).
//  The checksum is 8-bit XOR. Header bytes and the SYNC byte are excluded from it.
//  rx_valid low stalls any state indefinitely. There is no timeout.
//  reset asserted mid-frame: immediate return to the reset values. A partial frame is abandoned,
//   and words already written stay in memory.
//  A SYNC_BYTE value inside DATA/CNT/CHK is treated as data, not as a restart.
// STRUCTURE
//  Package loader_pkg: state enum (IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHK, RUN, ERR),
//   SYNC_BYTE default, WORD_BYTES=4.
//  Sub-module loader_word_asm: byte shift-in, 2-bit index, XOR checksum, word_full flag.
//   The top FSM, address and word counters, and the outputs stay in uart_mem_loader.
// TESTING
//  1 Reset held low mid-stream -> cpu_reset=1, rx_ready=1, ext_mem_write=0, addr=BASE_ADDR,
//    load_done=load_err=0.
//  2 Bytes 00 FF A5 02 00 78 56 34 12 EF BE AD DE 2A
//    -> write 0x12345678 @0x0, then 0xDEADBEEF @0x4.
//    -> Each strobe lasts one cycle; rx_ready=0 during it.
//    -> cpu_reset falls after the 2A byte; load_done=1.
//  3 Same frame with CHK=2B -> two writes occur; state ERR, load_err=1, cpu_reset stays 1.
//  4 A5 00 00 00 -> no writes; RUN. Then A5 01 00 11 22 33 44 00 -> cpu_reset=1 again.
//    -> Write 0x44332211 @0x0; CHK 00 != 44 -> ERR.
//  5 A5 41 00 (N=65 > MAX_WORDS) -> ERR right after CNT_HI; following data bytes are ignored.
//    -> A later valid frame recovers to RUN.
//  6 rx_valid toggled randomly during frame 2, plus reset asserted after 2 data words
//    -> identical writes; reset returns all outputs to reset values at once.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for the UART memory loader
package loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [2:0] stateT;

    localparam stateT stIdle  = 3'd0;
    localparam stateT stCntLo = 3'd1;
    localparam stateT stCntHi = 3'd2;
    localparam stateT stData  = 3'd3;
    localparam stateT stWrite = 3'd4;
    localparam stateT stChk   = 3'd5;
    localparam stateT stRun   = 3'd6;
    localparam stateT stErr   = 3'd7;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - little-endian byte-to-word assembler with running XOR checksum
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shiftEn,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic [7:0]  checksum,
    output logic        wordFull
);

    logic [1:0] byteIdx;

    // The first byte of a word ends up in bits [7:0] after four shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= 32'd0;
            checksum <= 8'd0;
            byteIdx  <= 2'd0;
        end else if (clear) begin
            word     <= 32'd0;
            checksum <= 8'd0;
            byteIdx  <= 2'd0;
        end else if (shiftEn) begin
            word     <= {byteIn, word[31:8]};
            checksum <= checksum ^ byteIn;
            byteIdx  <= byteIdx + 2'd1;
        end
    end

    // Asserted while the byte being accepted completes the current word.
    always_comb begin
        wordFull = shiftEn && (byteIdx == 2'(WORD_BYTES - 1));
    end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - framed UART boot loader writing data memory and gating CPU reset
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_reset,
    output logic        ext_mem_write,
    output logic [31:0] ext_write_data,
    output logic [31:0] ext_data_adr,
    output logic        load_done,
    output logic        load_err
);

    stateT       state;
    logic [7:0]  nLo;
    logic [15:0] nWords;
    logic [15:0] wordsDone;
    logic [31:0] addr;
    logic [31:0] word;
    logic [7:0]  checksum;
    logic        wordFull;
    logic        accept;
    logic        hunting;
    logic        syncAccept;
    logic        dataAccept;
    logic [15:0] cntFull;

    // Handshake decode; SYNC only restarts a frame from the idle, run and error states.
    always_comb begin
        accept     = rx_valid && rx_ready;
        hunting    = (state == stIdle) || (state == stRun) || (state == stErr);
        syncAccept = accept && hunting && (rx_data == SYNC_BYTE);
        dataAccept = accept && (state == stData);
        cntFull    = {rx_data, nLo};
    end

    loader_word_asm u_word_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (syncAccept),
        .shiftEn  (dataAccept),
        .byteIn   (rx_data),
        .word     (word),
        .checksum (checksum),
        .wordFull (wordFull)
    );

    // Frame sequencing, word count and write address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= stIdle;
            nLo       <= 8'd0;
            nWords    <= 16'd0;
            wordsDone <= 16'd0;
            addr      <= BASE_ADDR;
        end else begin
            case (state)
                stIdle, stRun, stErr: begin
                    if (syncAccept) begin
                        wordsDone <= 16'd0;
                        state     <= stCntLo;
                    end
                end
                stCntLo: begin
                    if (accept) begin
                        nLo   <= rx_data;
                        state <= stCntHi;
                    end
                end
                stCntHi: begin
                    if (accept) begin
                        nWords    <= cntFull;
                        wordsDone <= 16'd0;
                        addr      <= BASE_ADDR;
                        if (cntFull > 16'(MAX_WORDS)) begin
                            state <= stErr;
                        end else if (cntFull == 16'd0) begin
                            state <= stChk;
                        end else begin
                            state <= stData;
                        end
                    end
                end
                stData: begin
                    if (wordFull) begin
                        state <= stWrite;
                    end
                end
                stWrite: begin
                    addr      <= addr + 32'd4;
                    wordsDone <= wordsDone + 16'd1;
                    if (wordsDone + 16'd1 == nWords) begin
                        state <= stChk;
                    end else begin
                        state <= stData;
                    end
                end
                stChk: begin
                    if (accept) begin
                        state <= (rx_data == checksum) ? stRun : stErr;
                    end
                end
                default: state <= stIdle;
            endcase
        end
    end

    // Outputs decode directly from state so the strobe lasts exactly the WRITE cycle.
    always_comb begin
        rx_ready       = (state != stWrite);
        ext_mem_write  = (state == stWrite);
        ext_write_data = word;
        ext_data_adr   = addr;
        cpu_reset      = (state != stRun);
        load_done      = (state == stRun);
        load_err       = (state == stErr);
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        cpu_reset;
    logic        ext_mem_write;
    logic [31:0] ext_write_data;
    logic [31:0] ext_data_adr;
    logic        load_done;
    logic        load_err;

    uart_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .cpu_reset      (cpu_reset),
        .ext_mem_write  (ext_mem_write),
        .ext_write_data (ext_write_data),
        .ext_data_adr   (ext_data_adr),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit gapMode = 1'b0;
    bit prevWr = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        int          due;
    } wrT;

    wrT          expQ[$];
    logic [31:0] obsD[$];
    logic [31:0] obsA[$];

    // Frame-level model: which field of the frame the next byte belongs to.
    int          mPhase;
    bit          mRun;
    bit          mErr;
    logic [7:0]  mLo;
    logic [15:0] mN;
    logic [7:0]  mChk;
    int          mLeft;
    int          mK;
    logic [31:0] mWord;
    logic [31:0] mAdr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mRun   = 1'b0;
        mErr   = 1'b0;
        mChk   = 8'd0;
        expQ.delete();
    endtask

    task automatic modelByte(input logic [7:0] b, input int acc);
        case (mPhase)
            0: if (b == 8'hA5) begin
                mPhase = 1;
                mRun   = 1'b0;
                mErr   = 1'b0;
                mChk   = 8'd0;
            end
            1: begin
                mLo    = b;
                mPhase = 2;
            end
            2: begin
                mN = {b, mLo};
                if (mN > 16'd64) begin
                    mErr   = 1'b1;
                    mPhase = 0;
                end else if (mN == 16'd0) begin
                    mPhase = 4;
                end else begin
                    mPhase = 3;
                    mLeft  = 4 * int'(mN);
                    mK     = 0;
                    mWord  = 32'd0;
                    mAdr   = 32'd0;
                end
            end
            3: begin
                mWord = mWord | (32'(b) << (8 * mK));
                mChk  = mChk ^ b;
                mK++;
                mLeft--;
                if (mK == 4) begin
                    expQ.push_back('{d: mWord, a: mAdr, due: acc + 1});
                    mAdr  = mAdr + 32'd4;
                    mWord = 32'd0;
                    mK    = 0;
                end
                if (mLeft == 0) mPhase = 4;
            end
            default: begin
                if (b == mChk) mRun = 1'b1;
                else mErr = 1'b1;
                mPhase = 0;
            end
        endcase
    endtask

    // Call at a falling edge; returns at the falling edge after the byte is taken.
    task automatic sendByte(input logic [7:0] b);
        int acc;
        bit taken;
        taken = 1'b0;
        if (gapMode) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int w = 0; w < 20; w++) begin
            if (rx_ready) begin
                acc = cyc;
                @(posedge clk);
                modelByte(b, acc);
                taken = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!taken) begin
            total++;
            bad++;
            $display("FAIL handshake: byte %h never accepted", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic sendSeq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) sendByte(bytes[i]);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, " ext_mem_write"}, 32'(ext_mem_write), 32'd0);
        check({tag, " ext_write_data"}, ext_write_data, 32'd0);
        check({tag, " ext_data_adr"}, ext_data_adr, 32'd0);
        check({tag, " load_done"}, 32'(load_done), 32'd0);
        check({tag, " load_err"}, 32'(load_err), 32'd0);
    endtask

    // Per-cycle comparison of DUT outputs against the frame model.
    always @(negedge clk) begin
        if (reset) begin
            if (expQ.size() > 0 && cyc > expQ[0].due) begin
                total++;
                bad++;
                $display("FAIL missing_write: want %h @%h due cycle %0d", expQ[0].d, expQ[0].a, expQ[0].due);
                void'(expQ.pop_front());
            end
            if (ext_mem_write) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %h @%h want no write", ext_write_data, ext_data_adr);
                end else begin
                    check("write_data", ext_write_data, expQ[0].d);
                    check("write_adr", ext_data_adr, expQ[0].a);
                    check("write_cycle", 32'(cyc), 32'(expQ[0].due));
                    void'(expQ.pop_front());
                end
                check("write_cpu_held", 32'(cpu_reset), 32'd1);
                check("write_rx_ready", 32'(rx_ready), 32'd0);
                check("write_one_cycle", 32'(prevWr), 32'd0);
                obsD.push_back(ext_write_data);
                obsA.push_back(ext_data_adr);
            end
            check("load_done", 32'(load_done), 32'(mRun));
            check("load_err", 32'(load_err), 32'(mErr));
            check("cpu_reset", 32'(cpu_reset), 32'(!mRun));
            prevWr = ext_mem_write;
        end else begin
            prevWr = 1'b0;
        end
    end

    initial begin
        modelReset();
        // 1: reset state, then reset asserted mid-frame
        repeat (2) @(negedge clk);
        checkReset("t1_por");
        reset = 1'b1;
        @(negedge clk);
        sendSeq('{8'hA5, 8'h05, 8'h00, 8'h11, 8'h22});
        #2 reset = 1'b0;
        #1 checkReset("t1_mid");
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 2: good two-word frame preceded by junk
        obsD.delete(); obsA.delete();
        sendSeq('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A});
        check("t2_nwrites", 32'(obsD.size()), 32'd2);
        check("t2_d0", obsD[0], 32'h1234_5678);
        check("t2_a0", obsA[0], 32'h0000_0000);
        check("t2_d1", obsD[1], 32'hDEAD_BEEF);
        check("t2_a1", obsA[1], 32'h0000_0004);
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_cpu_run", 32'(cpu_reset), 32'd0);
        check("t2_adr_end", ext_data_adr, 32'h0000_0008);

        // 3: same frame, bad checksum
        obsD.delete(); obsA.delete();
        sendSeq('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B});
        check("t3_nwrites", 32'(obsD.size()), 32'd2);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_cpu_held", 32'(cpu_reset), 32'd1);

        // 4: empty frame runs, then reload with bad checksum
        obsD.delete(); obsA.delete();
        sendSeq('{8'hA5, 8'h00, 8'h00, 8'h00});
        check("t4_nwrites0", 32'(obsD.size()), 32'd0);
        check("t4_run", 32'(load_done), 32'd1);
        sendSeq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00});
        check("t4_nwrites1", 32'(obsD.size()), 32'd1);
        check("t4_d0", obsD[0], 32'h4433_2211);
        check("t4_a0", obsA[0], 32'h0000_0000);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_cpu_held", 32'(cpu_reset), 32'd1);

        // 5: oversize count rejected, trailing bytes ignored, then recovery
        obsD.delete(); obsA.delete();
        sendSeq('{8'hA5, 8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        check("t5_nwrites0", 32'(obsD.size()), 32'd0);
        check("t5_err", 32'(load_err), 32'd1);
        sendSeq('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        check("t5_d0", obsD[0], 32'h0403_0201);
        check("t5_run", 32'(load_done), 32'd1);

        // 6: stalled byte stream, reset after two words
        obsD.delete(); obsA.delete();
        gapMode = 1'b1;
        sendSeq('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE});
        gapMode = 1'b0;
        check("t6_nwrites", 32'(obsD.size()), 32'd2);
        check("t6_d0", obsD[0], 32'h1234_5678);
        check("t6_d1", obsD[1], 32'hDEAD_BEEF);
        check("t6_a1", obsA[1], 32'h0000_0004);
        #2 reset = 1'b0;
        #1 checkReset("t6_rst");
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
